multi_pattern_detector: RTL
===========================

// Module: multi_pattern_detector
// PURPOSE
//  Parametrised serial pattern detector: NPAT independent channels watch one 1-bit stream, each for a runtime-loaded pattern of 1..MAXLEN bits.
//  Generalises the fixed two-pattern detector: programmable patterns/lengths, in_valid qualifier, overlap/non-overlap mode, per-channel hit counters.
//  Sits after the serial bit source; match/z feed the control FSMs and status readout.
// PARAMETERS
//  NPAT    2   number of pattern channels (>=1)
//  MAXLEN  8   max pattern length in bits (>=2)
//  CNTW    8   per-channel hit counter width (saturating)
// PORTS
//  clk       in   1            clock; all state updates on rising edge
//  reset     in   1            synchronous, active-high reset
//  in_valid  in   1            'in' carries a stream bit this cycle
//  in        in   1            serial data bit
//  overlap   in   1            1 = overlapping matches counted; 0 = non-overlapping
//  cfg_load  in   1            latch cfg_* and restart all channels
//  cfg_en    in   NPAT         per-channel enable (latched on cfg_load)
//  cfg_len   in   NPAT*LENW    per-channel length, LENW=$clog2(MAXLEN+1) (latched)
//  cfg_pat   in   NPAT*MAXLEN  per-channel pattern, bit 0 arrives first, LSB-aligned (latched)
//  clr_cnt   in   1            clear all hit counters
//  match     out  NPAT         per-channel one-cycle match pulse
//  z         out  1            OR of match
//  hit_cnt   out  NPAT*CNTW    per-channel saturating match count
// BEHAVIOUR
//  Reset: hist=0, fill=0, match=0, z=0, hit_cnt=0, latched en=0/len=0/pat=0 (all channels disabled until first cfg_load).
//  History: on in_valid, hist <= {in, hist[MAXLEN-1:1]} (newest bit at MSB). in_valid=0: nothing changes, match=0.
//  Channel i window = hist_next[MAXLEN-1 -: len_i]; matches when window == pat_i[len_i-1:0]
//   (pat read as a binary string, rightmost bit first in time; e.g. 4'b0100 = arrival 0,0,1,0).
//  fill_i: valid bits seen by channel i, saturates at len_i; increments on each in_valid.
//  Match condition (evaluated on bit edge, using the incoming bit): in_valid & en_i & len_i in 1..MAXLEN & fill_i+1 >= len_i & window equal.
//  Latency: match[i] registered on the same edge that samples the final bit; high exactly one clock; z same cycle.
//  overlap=1: fill_i unchanged by a match (suffix may start next match).
//  overlap=0: fill_i <= 0 on match; next match needs len_i fresh bits.
//  hit_cnt[i] += 1 per match, saturates at 2^CNTW-1 (no wrap).
//  Invalid config: len_i==0 or len_i>MAXLEN -> channel never matches; pat bits above len_i ignored.
//  cfg_load: latches cfg_en/len/pat, clears hist and all fill; hit_cnt kept. Concurrent in_valid bit discarded, match=0 that cycle.
//  clr_cnt: hit_cnt <= 0; wins over a simultaneous match (match/z still pulse).
//  reset mid-stream: overrides all inputs; partial patterns lost; channels disabled.
//  overlap is sampled live each bit (not latched).
// STRUCTURE
//  Package multi_pattern_detector_pkg: LENW function/constant, len-valid check, helper to extract channel slice.
//  Top: shared hist shift register, cfg latch, generate loop of NPAT sub-modules, z OR-reduce.
//  Sub-module pattern_channel: window compare, fill counter, match register, hit counter.
// TESTING  (bits listed in arrival order; NPAT=2, MAXLEN=8, CNTW=8 unless stated)
//  1 ch0 pat=4'b0100 len4, ch1 pat=5'b00010 len5, overlap=1; stream 0,0,1,0,0,0 -> match[0] after bit4, match[1] after bit6,
//    z pulses both cycles, hit_cnt={1,1}.
//  2 ch0 pat=3'b101 len3; stream 1,0,1,0,1: overlap=1 -> matches after bits 3 and 5 (cnt 2); overlap=0 -> only bit 3 (cnt 1).
//  3 Case 1 stream with in_valid=0 idle cycles (random 'in') between bits -> identical match count; pulse only on valid edges.
//  4 Load ch0 4'b0100, send 0,0; cfg_load (same pattern) with in_valid=1 in=1; send 0 -> no match;
//    then 0,0,1,0 -> one match (no match spans the load).
//  5 CNTW=2: five matches -> hit_cnt[0]=3 held; clr_cnt coincident with 6th match -> hit_cnt=0, match[0] still pulses.
//  6 Reset after 3 of 4 bits of ch0 pattern -> all outputs 0, no match on 4th bit; reload cfg, full pattern -> match.

Source files
------------

// File: rtl/multi_pattern_detector_pkg.sv
// Shared helpers for the multi-channel serial pattern detector.
package multi_pattern_detector_pkg;

  // Width needed to hold a pattern length in the range 0..maxlen.
  function automatic int calc_lenw(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

  // A channel is only armed when its length is within 1..maxlen.
  function automatic logic len_ok(input int len, input int maxlen);
    return (len >= 1) && (len <= maxlen);
  endfunction

  // Low bit index of channel idx inside a flattened per-channel bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/multi_pattern_detector_pattern_channel.sv
// One detector channel: window compare against the latched pattern,
// fill counter (fresh bits seen), registered match pulse and a
// saturating hit counter.
module pattern_channel
  import multi_pattern_detector_pkg::*;
#(
  parameter  int MAXLEN = 8,
  parameter  int CNTW   = 8,
  localparam int LENW   = calc_lenw(MAXLEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              bit_valid,
  input  logic              overlap,
  input  logic [MAXLEN-1:0] hist_next,
  input  logic              en,
  input  logic [LENW-1:0]   len,
  input  logic [MAXLEN-1:0] pat,
  input  logic              clr_cnt,
  output logic              match,
  output logic [CNTW-1:0]   hit_cnt
);

  logic [LENW-1:0]   fill_q;
  logic [LENW-1:0]   fill_d;
  logic [LENW:0]     fill_inc;
  logic [MAXLEN-1:0] window;
  logic [MAXLEN-1:0] mask;
  logic              len_good;
  logic              full;
  logic              equal;
  logic              hit;
  logic              match_q;
  logic [CNTW-1:0]   cnt_q;

  // Window/pattern compare and fill-counter next state for the incoming bit.
  always_comb begin
    window   = '0;
    mask     = '0;
    len_good = len_ok(int'(len), MAXLEN);
    if (len_good) begin
      // Newest bit sits at the MSB, so the top len bits shifted down
      // leave the oldest bit of the window at bit 0, aligned with pat[0].
      window = hist_next >> (MAXLEN - int'(len));
    end
    for (int k = 0; k < MAXLEN; k++) begin
      mask[k] = (k < int'(len));
    end
    equal    = (((window ^ pat) & mask) == '0);
    fill_inc = {1'b0, fill_q} + 1'b1;
    full     = (fill_inc >= {1'b0, len});
    hit      = bit_valid & en & len_good & full & equal;
    fill_d   = fill_q;
    if (bit_valid) begin
      if (hit && !overlap) begin
        fill_d = '0;
      end else if (fill_q < len) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // Fill counter and one-cycle match register; a config reload restarts both.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      match_q <= hit;
    end
  end

  // Saturating hit counter; clear has priority over a coincident hit.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match   = match_q;
  assign hit_cnt = cnt_q;

endmodule

// File: rtl/multi_pattern_detector.sv
// Serial multi-pattern detector: a shared bit history feeds NPAT
// independently configured channels. Stream qualifier: a bit is
// consumed on a rising edge only when in_valid=1 (no back-pressure);
// a cfg_load in the same cycle discards that bit.
module multi_pattern_detector
  import multi_pattern_detector_pkg::*;
#(
  parameter  int NPAT   = 2,
  parameter  int MAXLEN = 8,
  parameter  int CNTW   = 8,
  localparam int LENW   = calc_lenw(MAXLEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in,
  input  logic                   overlap,
  input  logic                   cfg_load,
  input  logic [NPAT-1:0]        cfg_en,
  input  logic [NPAT*LENW-1:0]   cfg_len,
  input  logic [NPAT*MAXLEN-1:0] cfg_pat,
  input  logic                   clr_cnt,
  output logic [NPAT-1:0]        match,
  output logic                   z,
  output logic [NPAT*CNTW-1:0]   hit_cnt
);

  // Only the upper MAXLEN-1 history bits survive to the next compare,
  // so the register is one bit shorter than the window.
  logic [MAXLEN-2:0]      hist_q;
  logic [MAXLEN-1:0]      hist_next;
  logic                   bit_valid;
  logic [NPAT-1:0]        en_q;
  logic [NPAT*LENW-1:0]   len_q;
  logic [NPAT*MAXLEN-1:0] pat_q;

  assign bit_valid = in_valid & ~cfg_load;
  assign hist_next = {in, hist_q};

  // Shared history shift register, newest bit entering at the top.
  always_ff @(posedge clk) begin
    if (reset || cfg_load) begin
      hist_q <= '0;
    end else if (in_valid) begin
      hist_q <= hist_next[MAXLEN-1:1];
    end
  end

  // Configuration latch; all channels stay disabled until the first load.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q  <= '0;
      len_q <= '0;
      pat_q <= '0;
    end else if (cfg_load) begin
      en_q  <= cfg_en;
      len_q <= cfg_len;
      pat_q <= cfg_pat;
    end
  end

  for (genvar g = 0; g < NPAT; g++) begin : g_ch
    pattern_channel #(
      .MAXLEN (MAXLEN),
      .CNTW   (CNTW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .restart   (cfg_load),
      .bit_valid (bit_valid),
      .overlap   (overlap),
      .hist_next (hist_next),
      .en        (en_q[g]),
      .len       (len_q[slice_lo(g, LENW) +: LENW]),
      .pat       (pat_q[slice_lo(g, MAXLEN) +: MAXLEN]),
      .clr_cnt   (clr_cnt),
      .match     (match[g]),
      .hit_cnt   (hit_cnt[slice_lo(g, CNTW) +: CNTW])
    );
  end

  assign z = |match;

endmodule
